// File: rtl/parity_serial_tx.sv
// ============================================================================
// Module      : parity_serial_tx
// Description : Serial frame transmitter: start, 8 data bits LSB first,
//               parity, stop. Each bit held CLKS_PER_BIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            CW     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          C_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cnt_q == C_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in && ready_q) begin
          shreg_d = data_in;
          par_d   = (^data_in) ^ C_ODD;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          // Index saturates at 7; leaving DATA is decided on the last bit.
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_out = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
// ============================================================================
// Module      : tb_parity_serial_tx
// Description : Directed bench for parity_serial_tx with an expected-bit queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [3];
  logic [2:0] vin;
  logic [2:0] rdy, txs, bsy, dn;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q [$];

  always #5 clk = ~clk;

  // 0: 4 clk/bit even, 1: 4 clk/bit odd, 2: 1 clk/bit even
  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(vin[0]),
    .ready_out(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .done(dn[0]));
  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(vin[1]),
    .ready_out(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .done(dn[1]));
  parity_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(vin[2]),
    .ready_out(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s tx d%0d", tag, s),    txs[s], 1'b1);
      chk($sformatf("%s ready d%0d", tag, s), rdy[s], 1'b1);
      chk($sformatf("%s busy d%0d", tag, s),  bsy[s], 1'b0);
      chk($sformatf("%s done d%0d", tag, s),  dn[s],  1'b0);
    end
  endtask

  // Caller presents din/vin before the call; the next edge is the accept edge.
  // hold keeps valid_in high through the frame with nb presented for the next.
  task automatic send(input int s, input logic [7:0] b, input logic p,
                      input bit hold, input logic [7:0] nb);
    int cpb;
    bit e;
    cpb = (s == 2) ? 1 : 4;
    @(posedge clk); #1;
    vin[s] = hold;
    exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      for (int j = 0; j < cpb; j++) begin
        if (!(i == 0 && j == 0)) begin
          @(posedge clk); #1;
        end
        chk($sformatf("tx d%0d %02h bit%0d cyc%0d", s, b, i, j), txs[s], e);
        chk($sformatf("busy d%0d %02h bit%0d", s, b, i),  bsy[s], 1'b1);
        chk($sformatf("ready d%0d %02h bit%0d", s, b, i), rdy[s], 1'b0);
        chk($sformatf("done d%0d %02h bit%0d", s, b, i),  dn[s],  1'b0);
        din[s] = (i == 10 && j == cpb - 1) ? nb : 8'($urandom);
      end
    end
    @(posedge clk); #1;
    chk($sformatf("end done d%0d %02h", s, b),  dn[s],  1'b1);
    chk($sformatf("end busy d%0d %02h", s, b),  bsy[s], 1'b0);
    chk($sformatf("end ready d%0d %02h", s, b), rdy[s], 1'b1);
    chk($sformatf("end tx d%0d %02h", s, b),    txs[s], 1'b1);
  endtask

  task automatic idle_cycle(input int s);
    @(posedge clk); #1;
    chk($sformatf("idle done d%0d", s), dn[s],  1'b0);
    chk($sformatf("idle tx d%0d", s),   txs[s], 1'b1);
    chk($sformatf("idle ready d%0d", s), rdy[s], 1'b1);
  endtask

  logic [7:0] ev_b [7] = '{8'h01, 8'h00, 8'hAA, 8'hFF, 8'hCC, 8'h81, 8'h80};
  logic       ev_p [7] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

  initial begin
    vin = '0;
    for (int s = 0; s < 3; s++) din[s] = 8'h00;

    #12;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("post-reset");

    // reset while idle
    #3 rst = 1'b1;
    #1 chk_idle("idle-reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("idle-reset release");

    // even parity frames, 8'h01 first
    for (int v = 0; v < 7; v++) begin
      din[0] = ev_b[v];
      vin[0] = 1'b1;
      send(0, ev_b[v], ev_p[v], 1'b0, 8'h00);
      idle_cycle(0);
    end

    // odd parity
    din[1] = 8'h00; vin[1] = 1'b1;
    send(1, 8'h00, 1'b1, 1'b0, 8'h00);
    idle_cycle(1);
    din[1] = 8'hFF; vin[1] = 1'b1;
    send(1, 8'hFF, 1'b1, 1'b0, 8'h00);
    idle_cycle(1);

    // back-to-back with valid held high and data_in toggling mid-frame
    din[0] = 8'hA5; vin[0] = 1'b1;
    send(0, 8'hA5, 1'b0, 1'b1, 8'h3C);
    send(0, 8'h3C, 1'b0, 1'b0, 8'h00);
    idle_cycle(0);

    // one clock per bit
    din[2] = 8'h7E; vin[2] = 1'b1;
    send(2, 8'h7E, 1'b0, 1'b0, 8'h00);
    idle_cycle(2);

    // reset in the middle of DATA
    din[0] = 8'h55; vin[0] = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("pre-reset busy", bsy[0], 1'b1);
    #2 rst = 1'b1;
    #1 chk_idle("data-reset");
    #2 rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      chk($sformatf("after abort done c%0d", c), dn[0], 1'b0);
      chk($sformatf("after abort tx c%0d", c),   txs[0], 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
